// File: rtl/macplus_sdram_ctrl_if.sv
// Mac Plus core RAM bus as seen by the SDRAM controller.
// Phase, address, write data, strobes and requests come from the core; read data goes back to it.
interface macplus_sdram_ctrl_if;
    logic [2:0]  busPhase;
    logic [20:0] ram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_ds;
    logic        sdram_we;
    logic        sdram_oe;
    logic [15:0] sdram_do;

    modport master (
        output busPhase, ram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe,
        input  sdram_do
    );

    modport slave (
        input  busPhase, ram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe,
        output sdram_do
    );
endinterface

// File: rtl/macplus_sdram_ctrl.sv
// Maps each 8-phase Mac Plus bus slot onto one ACTIVE + READ/WRITE (auto-precharge) SDRAM access,
// with power-up init sequence and refresh squeezed into idle slots.
module macplus_sdram_ctrl #(
    parameter int          INIT_CYCLES    = 3200,
    parameter int          REFRESH_CYCLES = 250,
    parameter int          REFRESH_MAX    = 7,
    parameter logic [12:0] MODE_REG       = 13'h020
) (
    input  logic                 clk_sys,
    input  logic                 RESET,
    macplus_sdram_ctrl_if.slave  bus,
    output logic                 init_done,
    output logic                 sd_cke,
    output logic                 sd_cs_n,
    output logic                 sd_ras_n,
    output logic                 sd_cas_n,
    output logic                 sd_we_n,
    output logic [1:0]           sd_ba,
    output logic [12:0]          sd_addr,
    output logic [1:0]           sd_dqm,
    output logic [15:0]          sd_dq_o,
    output logic                 sd_dq_oe,
    input  logic [15:0]          sd_dq_i
);

    localparam int WAIT_W = $clog2(INIT_CYCLES + 1);
    localparam int TICK_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int PEND_W = $clog2(REFRESH_MAX + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(REFRESH_MAX);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_REF,
        INIT_MODE,
        RUN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cmd;
    logic [3:0]        cmd_nx;
    logic [12:0]       addr_nx;
    logic [1:0]        dqm_nx;
    logic              dq_oe_nx;
    logic              write_go;
    logic              ref_dec;
    logic              rd_capture;
    logic              enter_run;
    logic              tick;
    logic              p1;
    logic              p3;
    logic              p6;

    logic [WAIT_W-1:0] wait_cnt;
    logic [2:0]        init_ref_cnt;
    logic [TICK_W-1:0] tick_cnt;
    logic [PEND_W-1:0] pending;
    logic              slot_oe;
    logic              slot_we;
    logic [8:0]        slot_col;

    assign p1   = (bus.busPhase == 3'd1);
    assign p3   = (bus.busPhase == 3'd3);
    assign p6   = (bus.busPhase == 3'd6);
    assign tick = (tick_cnt == TICK_LAST);

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;
    assign sd_ba = 2'b00;

    always_comb begin
        state_nx   = state;
        cmd_nx     = CMD_NOP;
        addr_nx    = 13'h0000;
        dqm_nx     = 2'b11;
        dq_oe_nx   = 1'b0;
        write_go   = 1'b0;
        ref_dec    = 1'b0;
        rd_capture = 1'b0;
        enter_run  = 1'b0;
        case (state)
            INIT_WAIT: begin
                if (wait_cnt == WAIT_LAST)
                    state_nx = INIT_PRE;
            end
            INIT_PRE: begin
                if (p1) begin
                    cmd_nx   = CMD_PRECHARGE;
                    addr_nx  = 13'h0400;
                    state_nx = INIT_REF;
                end
            end
            INIT_REF: begin
                if (p1) begin
                    cmd_nx = CMD_REFRESH;
                    if (init_ref_cnt == 3'd7)
                        state_nx = INIT_MODE;
                end
            end
            INIT_MODE: begin
                if (p1) begin
                    cmd_nx    = CMD_LOAD_MODE;
                    addr_nx   = MODE_REG;
                    state_nx  = RUN;
                    enter_run = 1'b1;
                end
            end
            RUN: begin
                if (p1) begin
                    if (bus.sdram_we || bus.sdram_oe) begin
                        cmd_nx  = CMD_ACTIVE;
                        addr_nx = {1'b0, bus.ram_addr[20:9]};
                    end else if (pending != '0) begin
                        cmd_nx  = CMD_REFRESH;
                        ref_dec = 1'b1;
                    end
                end
                // Column access two clocks after ACTIVE, A10 set for auto-precharge
                if (p3 && (slot_oe || slot_we)) begin
                    cmd_nx   = slot_we ? CMD_WRITE : CMD_READ;
                    addr_nx  = {3'b001, 1'b0, slot_col};
                    dqm_nx   = ~bus.sdram_ds;
                    dq_oe_nx = slot_we;
                    write_go = slot_we;
                end
                if (p6 && slot_oe && !slot_we)
                    rd_capture = 1'b1;
            end
            default: state_nx = INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state        <= INIT_WAIT;
            cmd          <= CMD_INHIBIT;
            sd_addr      <= 13'h0000;
            sd_dqm       <= 2'b11;
            sd_dq_oe     <= 1'b0;
            sd_cke       <= 1'b1;
            wait_cnt     <= '0;
            init_ref_cnt <= 3'd0;
            tick_cnt     <= '0;
            pending      <= '0;
            slot_oe      <= 1'b0;
            slot_we      <= 1'b0;
            init_done    <= 1'b0;
            bus.sdram_do <= 16'h0000;
        end else begin
            state    <= state_nx;
            cmd      <= cmd_nx;
            sd_addr  <= addr_nx;
            sd_dqm   <= dqm_nx;
            sd_dq_oe <= dq_oe_nx;
            sd_cke   <= 1'b1;
            if (state == INIT_WAIT && wait_cnt != WAIT_LAST)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (state == INIT_REF && p1)
                init_ref_cnt <= init_ref_cnt + 3'd1;
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            // A tick and a refresh on the same edge cancel out
            if (enter_run)
                pending <= '0;
            else if (tick && !ref_dec) begin
                if (pending != PEND_MAX)
                    pending <= pending + PEND_W'(1);
            end else if (ref_dec && !tick)
                pending <= pending - PEND_W'(1);
            if (enter_run)
                init_done <= 1'b1;
            if (state == RUN && p1) begin
                slot_oe <= bus.sdram_oe;
                slot_we <= bus.sdram_we;
            end
            if (rd_capture)
                bus.sdram_do <= sd_dq_i;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (state == RUN && p1)
            slot_col <= bus.ram_addr[8:0];
        if (write_go)
            sd_dq_o <= bus.sdram_din;
    end

endmodule

// File: tb/tb_macplus_sdram_ctrl.sv
// Directed bench for macplus_sdram_ctrl: init sequence, read, byte write, refresh, conflict, mid-access reset.
module tb_macplus_sdram_ctrl;

    localparam int INIT_CYC = 16;
    localparam int REF_CYC  = 64;

    localparam logic [3:0] C_INH  = 4'b1111;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MODE = 4'b0000;

    logic        clk_sys = 1'b0;
    logic        RESET   = 1'b1;
    logic        init_done, sd_cke, sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n, sd_dq_oe;
    logic [1:0]  sd_ba, sd_dqm;
    logic [12:0] sd_addr;
    logic [15:0] sd_dq_o;
    logic [15:0] sd_dq_i = 16'hDEAD;
    logic [3:0]  cmd;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    macplus_sdram_ctrl_if bus();

    macplus_sdram_ctrl #(
        .INIT_CYCLES(INIT_CYC), .REFRESH_CYCLES(REF_CYC), .REFRESH_MAX(7), .MODE_REG(13'h020)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .bus(bus), .init_done(init_done),
        .sd_cke(sd_cke), .sd_cs_n(sd_cs_n), .sd_ras_n(sd_ras_n), .sd_cas_n(sd_cas_n),
        .sd_we_n(sd_we_n), .sd_ba(sd_ba), .sd_addr(sd_addr), .sd_dqm(sd_dqm),
        .sd_dq_o(sd_dq_o), .sd_dq_oe(sd_dq_oe), .sd_dq_i(sd_dq_i)
    );

    assign cmd = {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n};

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    initial begin
        bus.busPhase = 3'd0;
        forever begin
            @(posedge clk_sys);
            #1 bus.busPhase = bus.busPhase + 3'd1;
        end
    end

    // SDRAM model: row from ACTIVE, column access merges bytes or schedules CL2 read data
    logic [15:0] mem [int];
    logic [11:0] row = 12'h0;
    logic [15:0] rd_val = 16'h0;
    logic        rd_armed = 1'b0;
    initial begin
        forever begin
            @(negedge clk_sys);
            if (cmd == C_ACT) row = sd_addr[11:0];
            if (cmd == C_RD) begin
                rd_val   = mem.exists(int'({row, sd_addr[8:0]})) ? mem[int'({row, sd_addr[8:0]})] : 16'h0000;
                rd_armed = 1'b1;
            end
            if (cmd == C_WR && sd_dq_oe) begin
                logic [15:0] w;
                w = mem.exists(int'({row, sd_addr[8:0]})) ? mem[int'({row, sd_addr[8:0]})] : 16'h0000;
                if (!sd_dqm[1]) w[15:8] = sd_dq_o[15:8];
                if (!sd_dqm[0]) w[7:0]  = sd_dq_o[7:0];
                mem[int'({row, sd_addr[8:0]})] = w;
            end
            if (bus.busPhase == 3'd6 && rd_armed) begin
                sd_dq_i  = rd_val;
                rd_armed = 1'b0;
            end else begin
                sd_dq_i = 16'hDEAD;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_neg_phase(input logic [2:0] p);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_sys);
            if (bus.busPhase == p) return;
        end
        check("phase_wait", 32'd0, 32'd1);
    endtask

    task automatic run_slot(input logic oe, input logic we, input logic [20:0] a,
                            input logic [15:0] din, input logic [1:0] ds,
                            output logic [3:0] c1, output logic [12:0] a1,
                            output logic [3:0] c3, output logic [12:0] a3,
                            output logic [1:0] dqm3, output logic oe3, output logic [15:0] dqo3,
                            output logic oe4, output logic [15:0] do7);
        wait_neg_phase(3'd0);
        bus.sdram_oe = oe; bus.sdram_we = we; bus.ram_addr = a;
        bus.sdram_din = din; bus.sdram_ds = ds;
        wait_neg_phase(3'd2);
        c1 = cmd; a1 = sd_addr;
        wait_neg_phase(3'd4);
        c3 = cmd; a3 = sd_addr; dqm3 = sd_dqm; oe3 = sd_dq_oe; dqo3 = sd_dq_o;
        wait_neg_phase(3'd5);
        oe4 = sd_dq_oe;
        wait_neg_phase(3'd7);
        do7 = bus.sdram_do;
        bus.sdram_oe = 1'b0; bus.sdram_we = 1'b0;
    endtask

    logic [3:0]  c1, c3;
    logic [12:0] a1, a3;
    logic [1:0]  dqm3;
    logic        oe3, oe4;
    logic [15:0] dqo3, do7;

    logic [3:0]  ev_cmd [16];
    logic [12:0] ev_addr [16];
    int          ev_cyc [16];
    logic [2:0]  ev_ph [16];

    initial begin
        int ne, rel_cyc, bad_cmd, do_nz, gap_bad, n_ref, done_at_mode, reached, refs;
        bus.sdram_oe = 1'b0; bus.sdram_we = 1'b0; bus.ram_addr = 21'h0;
        bus.sdram_din = 16'h0; bus.sdram_ds = 2'b11;

        // reset state
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_cmd", cmd, C_INH);
        check("rst_cke", sd_cke, 1);
        check("rst_dq_oe", sd_dq_oe, 0);
        check("rst_dqm", sd_dqm, 2'b11);
        check("rst_do", bus.sdram_do, 0);
        check("rst_init_done", init_done, 0);
        RESET = 1'b0;
        rel_cyc = cyc;

        // init sequence with a stray read request held the whole time
        bus.sdram_oe = 1'b1; bus.ram_addr = 21'h1ABCD;
        ne = 0; bad_cmd = 0; do_nz = 0; done_at_mode = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (bus.sdram_do != 16'h0) do_nz++;
            if (cmd == C_ACT || cmd == C_RD || cmd == C_WR) bad_cmd++;
            if (cmd != C_NOP && !cmd[3] && ne < 16) begin
                ev_cmd[ne] = cmd; ev_addr[ne] = sd_addr; ev_cyc[ne] = cyc; ev_ph[ne] = bus.busPhase;
                ne++;
            end
            if (init_done) begin
                done_at_mode = (cmd == C_MODE) ? 1 : 0;
                break;
            end
        end
        bus.sdram_oe = 1'b0;
        check("init_n_cmds", ne, 10);
        check("init_pre_cmd", ev_cmd[0], C_PRE);
        check("init_pre_a10", ev_addr[0][10], 1);
        check("init_pre_phase", ev_ph[0], 3'd2);
        check("init_pre_after_wait", (ev_cyc[0] - rel_cyc) >= INIT_CYC, 1);
        gap_bad = 0; n_ref = 0;
        for (int i = 1; i < 10; i++) begin
            if (ev_cyc[i] - ev_cyc[i-1] != 8) gap_bad++;
            if (i <= 8 && ev_cmd[i] == C_REF) n_ref++;
        end
        check("init_spacing_errs", gap_bad, 0);
        check("init_ref_count", n_ref, 8);
        check("init_mode_cmd", ev_cmd[9], C_MODE);
        check("init_mode_addr", ev_addr[9], 13'h020);
        check("init_done_with_mode", done_at_mode, 1);
        check("init_no_access", bad_cmd, 0);
        check("init_do_zero", do_nz, 0);

        mem[int'(21'h1ABCD)] = 16'hBEEF;
        mem[int'(21'h00123)] = 16'h5678;

        // read
        run_slot(1'b1, 1'b0, 21'h1ABCD, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("rd_act", c1, C_ACT);
        check("rd_row", a1, 13'h0D5);
        check("rd_cmd", c3, C_RD);
        check("rd_col", a3, 13'h5CD);
        check("rd_dqm", dqm3, 2'b00);
        check("rd_dq_oe", oe3, 0);
        check("rd_data", do7, 16'hBEEF);

        // upper-byte write
        run_slot(1'b0, 1'b1, 21'h00123, 16'h1234, 2'b10, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("wr_act", c1, C_ACT);
        check("wr_cmd", c3, C_WR);
        check("wr_col", a3, 13'h523);
        check("wr_dqm", dqm3, 2'b01);
        check("wr_dq", dqo3, 16'h1234);
        check("wr_dq_oe", oe3, 1);
        check("wr_dq_oe_pulse", oe4, 0);
        check("wr_do_held", do7, 16'hBEEF);

        run_slot(1'b1, 1'b0, 21'h00123, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("wr_readback", do7, 16'h1278);

        // oe and we together: write wins
        run_slot(1'b1, 1'b1, 21'h00200, 16'hCAFE, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("cf_cmd", c3, C_WR);
        check("cf_dq", dqo3, 16'hCAFE);
        check("cf_do_held", do7, 16'h1278);

        // refresh: drain, build pending to 2 under load, then three idle slots
        for (int i = 0; i < 40 && dut.pending != 0; i++)
            run_slot(1'b0, 1'b0, 21'h0, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        reached = 0;
        for (int i = 0; i < 40; i++) begin
            run_slot(1'b1, 1'b0, 21'h1ABCD, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
            if (dut.pending == 2) begin
                reached = 1;
                break;
            end
        end
        check("ref_reach2", reached, 1);
        run_slot(1'b0, 1'b0, 21'h0, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("ref_idle1", c1, C_REF);
        check("ref_idle1_p3", c3, C_NOP);
        run_slot(1'b0, 1'b0, 21'h0, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("ref_idle2", c1, C_REF);
        run_slot(1'b0, 1'b0, 21'h0, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("ref_idle3", c1, C_NOP);

        // saturation under continuous requests (10 ticks)
        for (int i = 0; i < 80; i++)
            run_slot(1'b1, 1'b0, 21'h1ABCD, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
        check("ref_saturate", dut.pending, 7);
        refs = 0;
        for (int i = 0; i < 7; i++) begin
            run_slot(1'b0, 1'b0, 21'h0, 16'h0, 2'b11, c1, a1, c3, a3, dqm3, oe3, dqo3, oe4, do7);
            if (c1 == C_REF) refs++;
        end
        check("ref_sat_drain", refs, 7);

        // reset in the middle of a read slot
        check("mr_do_before", bus.sdram_do, 16'hBEEF);
        wait_neg_phase(3'd0);
        bus.sdram_oe = 1'b1; bus.ram_addr = 21'h1ABCD;
        wait_neg_phase(3'd4);
        RESET = 1'b1;
        @(negedge clk_sys);
        check("mr_cmd", cmd, C_INH);
        check("mr_do", bus.sdram_do, 0);
        check("mr_init_done", init_done, 0);
        check("mr_dqm", sd_dqm, 2'b11);
        RESET = 1'b0;
        rel_cyc = cyc;
        bus.sdram_oe = 1'b0;
        ne = 0; do_nz = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_sys);
            if (bus.sdram_do != 16'h0) do_nz++;
            if (cmd != C_NOP && !cmd[3]) begin
                ev_cmd[0] = cmd; ev_cyc[0] = cyc; ne = 1;
                break;
            end
        end
        check("mr_restart_seen", ne, 1);
        check("mr_restart_pre", ev_cmd[0], C_PRE);
        check("mr_restart_wait", (ev_cyc[0] - rel_cyc) >= INIT_CYC, 1);
        check("mr_do_stays_zero", do_nz, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
